// File: rtl/dreg_pipe_chain_if.sv
// dreg_pipe_chain_if: producer/consumer handshake bundle for dreg_pipe_chain
//  master: drives flush, in_valid, in_data, out_ready; sees in_ready, out_valid, out_data, count
//  slave : the chain itself (mirror directions)
interface dreg_pipe_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0]               in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               out_data;
  logic [$clog2(DEPTH+1)-1:0]     count;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/dreg_pipe_chain.sv
// dreg_pipe_chain: elastic chain of DEPTH valid-tagged WIDTH-bit register stages
//  clk, rst (sync, active-high); bus: flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, count
module dreg_pipe_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  dreg_pipe_chain_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0]             v_q, v_d, adv, take;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d, src;
  logic [CW-1:0]                count_q, count_d;
  logic                         hole, fire;
  // a stage advances when some later stage is empty or the consumer takes the last word
  always_comb begin
    hole = bus.out_ready;
    adv = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i] = v_q[i] & hole;
      hole = hole | ~v_q[i];
    end
  end
  assign bus.in_ready  = (~v_q[0] | adv[0]) & ~bus.flush & ~rst;
  assign fire          = bus.in_valid & bus.in_ready;
  // stage i loads from src[i]: the input word for stage 0, the previous stage otherwise
  assign src           = (DEPTH*WIDTH)'({data_q, bus.in_data});
  assign take          = DEPTH'({adv, fire});
  always_comb begin
    v_d = '0;
    data_d = data_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = ~bus.flush & (take[i] | (v_q[i] & ~adv[i]));
      data_d[i] = (take[i] & ~bus.flush) ? src[i] : data_q[i];
      count_d = count_d + CW'(v_d[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      data_q <= {DEPTH{RESET_VAL}};
      count_q <= '0;
    end else begin
      v_q <= v_d;
      data_q <= data_d;
      count_q <= count_d;
    end
  end
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_dreg_pipe_chain.sv
// tb_dreg_pipe_chain: directed self-checking bench for dreg_pipe_chain (WIDTH=8, DEPTH=3)
module tb_dreg_pipe_chain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  dreg_pipe_chain_if #(.WIDTH(8), .DEPTH(3)) bus ();
  dreg_pipe_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = ordy;
    #1;
  endtask
  task automatic out_is(input string tag, input logic v, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
  endtask
  initial begin
    logic [7:0] s2 [3];
    logic [1:0] c2 [3];
    logic [7:0] a3 [4];
    s2 = '{8'h11, 8'h22, 8'h33};
    c2 = '{2'd3, 2'd2, 2'd1};
    a3 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    // 1: reset with random input activity
    repeat (2) begin
      bus.in_valid = 1'($urandom);
      bus.in_data = 8'($urandom);
      cyc();
    end
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_count", 32'(bus.count), 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    // 2: unstalled stream, 3-cycle latency
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, s2[k], 1'b1);
      chk("s2_in_ready", 32'(bus.in_ready), 1);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      out_is("s2_out", 1'b1, s2[k]);
      chk("s2_count", 32'(bus.count), 32'(c2[k]));
      cyc();
    end
    out_is("s2_empty", 1'b0, 8'h00);
    chk("s2_count_end", 32'(bus.count), 0);
    // 3: backpressure
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, a3[k], 1'b0);
      chk("s3_accept", 32'(bus.in_ready), 1);
      cyc();
    end
    drive(1'b1, a3[3], 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("s3_full_count", 32'(bus.count), 3);
      chk("s3_full_ready", 32'(bus.in_ready), 0);
      out_is("s3_hold", 1'b1, 8'hA1);
      cyc();
    end
    drive(1'b1, a3[3], 1'b1);
    chk("s3_pass_ready", 32'(bus.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      out_is("s3_out", 1'b1, a3[k]);
      cyc();
      drive(1'b0, 8'h00, 1'b1);
    end
    out_is("s3_empty", 1'b0, 8'h00);
    // 4: bubble collapse under stall
    drive(1'b1, 8'h5C, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("s4_ready1", 32'(bus.in_ready), 1);
    out_is("s4_c1", 1'b0, 8'h00);
    cyc();
    chk("s4_ready2", 32'(bus.in_ready), 1);
    out_is("s4_c2", 1'b0, 8'h00);
    cyc();
    out_is("s4_c3", 1'b1, 8'h5C);
    chk("s4_count", 32'(bus.count), 1);
    chk("s4_ready3", 32'(bus.in_ready), 1);
    cyc();
    out_is("s4_c4", 1'b1, 8'h5C);
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    out_is("s4_drained", 1'b0, 8'h00);
    // 5: full pass-through
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 8'(k), 1'b0);
      cyc();
    end
    drive(1'b1, 8'h04, 1'b1);
    chk("s5_ready", 32'(bus.in_ready), 1);
    chk("s5_count_pre", 32'(bus.count), 3);
    out_is("s5_out1", 1'b1, 8'h01);
    cyc();
    drive(1'b0, 8'h00, 1'b1);
    chk("s5_count_post", 32'(bus.count), 3);
    for (int k = 2; k <= 4; k++) begin
      out_is("s5_drain", 1'b1, 8'(k));
      cyc();
    end
    chk("s5_count_end", 32'(bus.count), 0);
    // 6a: flush mid-stream
    drive(1'b1, 8'hE1, 1'b0);
    cyc();
    drive(1'b1, 8'hE2, 1'b0);
    cyc();
    chk("s6_count2", 32'(bus.count), 2);
    bus.flush = 1'b1;
    drive(1'b1, 8'hEE, 1'b0);
    chk("s6_flush_ready", 32'(bus.in_ready), 0);
    cyc();
    bus.flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("s6_flush_count", 32'(bus.count), 0);
    for (int k = 0; k < 4; k++) begin
      out_is("s6_flush_none", 1'b0, 8'h00);
      cyc();
    end
    // 6b: reset mid-stream
    drive(1'b1, 8'hE1, 1'b0);
    cyc();
    drive(1'b1, 8'hE2, 1'b0);
    cyc();
    chk("s6r_count2", 32'(bus.count), 2);
    rst = 1'b1;
    drive(1'b1, 8'hEE, 1'b0);
    chk("s6r_ready", 32'(bus.in_ready), 0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("s6r_count", 32'(bus.count), 0);
    chk("s6r_out_data", 32'(bus.out_data), 32'h00);
    for (int k = 0; k < 4; k++) begin
      out_is("s6r_none", 1'b0, 8'h00);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
